// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 8 lines of 4 bytes.
// The CPU side is byte-wide with a BUSYWAIT stall. The memory side moves whole
// 32-bit blocks with a request/MEM_BUSYWAIT handshake.
module data_cache (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [7:0]  i_address,
  input  logic [7:0]  i_write_data,
  output logic [7:0]  o_read_data,
  output logic        o_busywait,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [5:0]  o_mem_address,
  output logic [31:0] o_mem_writedata,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_t;

  state_t      r_state;
  logic [31:0] r_data [8];
  logic [2:0]  r_tag  [8];
  logic [7:0]  r_valid;
  logic [7:0]  r_dirty;
  logic [31:0] r_block;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [5:0]  r_mem_address;
  logic [31:0] r_mem_writedata;

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic        w_req;
  logic        w_hit;
  logic [31:0] w_line;
  logic [4:0]  w_bit_base;

  assign w_tag      = i_address[7:5];
  assign w_index    = i_address[4:2];
  assign w_offset   = i_address[1:0];
  assign w_bit_base = {w_offset, 3'b000};
  assign w_req      = i_read | i_write;
  assign w_line     = r_data[w_index];
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Load data is combinational so a read hit completes in the same cycle. A
  // non-hit returns zero, which also keeps the port quiet right after reset
  // while the unreset data array still holds stale contents.
  assign o_read_data = w_hit ? w_line[w_bit_base +: 8] : 8'h00;

  // Stall only on a missing request while idle; every other state is mid-miss.
  assign o_busywait = (r_state == S_IDLE) ? (w_req && !w_hit) : 1'b1;

  assign o_mem_read      = r_mem_read;
  assign o_mem_write     = r_mem_write;
  assign o_mem_address   = r_mem_address;
  assign o_mem_writedata = r_mem_writedata;

  // Miss controller: state, valid/dirty bits and registered memory requests.
  // NOTE: every register here uses non-blocking assignment so all updates
  // within one edge see the pre-edge values, matching the hardware.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_dirty         <= '0;
      r_block         <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              // A simultaneous read and write is treated as a write.
              if (i_write) r_dirty[w_index] <= 1'b1;
            end else if (r_dirty[w_index]) begin
              r_mem_write     <= 1'b1;
              r_mem_address   <= {r_tag[w_index], w_index};
              r_mem_writedata <= w_line;
              r_state         <= S_WRITEBACK;
            end else begin
              r_mem_read    <= 1'b1;
              r_mem_address <= i_address[7:2];
              r_state       <= S_FETCH;
            end
          end
        end
        S_WRITEBACK: begin
          if (!i_mem_busywait) begin
            // The write request drops and the fetch request rises on the same
            // edge, so the two are never high together.
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b1;
            r_mem_address <= i_address[7:2];
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!i_mem_busywait) begin
            r_mem_read <= 1'b0;
            r_block    <= i_mem_readdata;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_valid[w_index] <= 1'b1;
          r_dirty[w_index] <= 1'b0;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage: block refill on UPDATE, byte merge on an idle write hit.
  // NOTE: the data and tag arrays are deliberately not reset; clearing the
  // valid bits is enough to make their contents unreachable.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_UPDATE) begin
        r_data[w_index] <= r_block;
        r_tag[w_index]  <= w_tag;
      end else if ((r_state == S_IDLE) && i_write && w_hit) begin
        r_data[w_index][w_bit_base +: 8] <= i_write_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed test for data_cache: a block memory model with fixed latency sits
// on the memory port and a CPU task issues held requests until BUSYWAIT falls.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_address;
  logic [7:0]  cpu_write_data;
  logic [7:0]  read_data;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int n_total;
  int n_bad;

  // Memory model state.
  logic [31:0] mem [64];
  int          mem_cnt;
  int          mem_lat;
  logic        mem_req;

  // Per-access observations.
  logic        saw_rd;
  logic        saw_wr;
  logic        saw_both;
  logic [5:0]  rd_addr;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  int          stalls;
  logic [7:0]  rdata;
  logic        done;

  data_cache dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_read          (cpu_read),
    .i_write         (cpu_write),
    .i_address       (cpu_address),
    .i_write_data    (cpu_write_data),
    .o_read_data     (read_data),
    .o_busywait      (busywait),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_mem_address   (mem_address),
    .o_mem_writedata (mem_writedata),
    .i_mem_readdata  (mem_readdata),
    .i_mem_busywait  (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory is busy from the cycle the request rises until mem_lat cycles have
  // passed; completion is the edge where the request is high and busy is low.
  assign mem_req      = mem_read | mem_write;
  assign mem_busywait = mem_req && (mem_cnt < mem_lat - 1);
  assign mem_readdata = mem[mem_address];

  always @(posedge clk) begin
    if (!mem_req || !mem_busywait) mem_cnt <= 0;
    else                           mem_cnt <= mem_cnt + 1;
    if (mem_write && !mem_busywait && !rst) mem[mem_address] <= mem_writedata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one CPU request, hold it until BUSYWAIT is low at a negedge, then
  // drop it after the following posedge. Records stalls and memory activity.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, input string tag);
    @(posedge clk);
    #1;
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_address    = addr;
    cpu_write_data = wd;
    stalls   = 0;
    saw_rd   = 1'b0;
    saw_wr   = 1'b0;
    saw_both = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    done     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_read) begin saw_rd = 1'b1; rd_addr = mem_address; end
      if (mem_write) begin saw_wr = 1'b1; wr_addr = mem_address; wr_data = mem_writedata; end
      if (mem_read && mem_write) saw_both = 1'b1;
      if (!busywait) begin done = 1'b1; break; end
      stalls++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_excl"}, {31'd0, saw_both}, 32'd0);
    rdata = read_data;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    mem_lat = 5;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h00] = 32'hDDCCBBAA;
    mem[6'h08] = 32'h44332211;
    mem[6'h11] = 32'h87654321;
    mem[6'h01] = 32'hA1B2C3D4;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_write_data = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  {31'd0, busywait},  32'd0);
    check("rst_mrd",   {31'd0, mem_read},  32'd0);
    check("rst_mwr",   {31'd0, mem_write}, 32'd0);
    check("rst_maddr", {26'd0, mem_address}, 32'd0);
    check("rst_mwdata", mem_writedata, 32'd0);
    check("rst_rdata", {24'd0, read_data}, 32'd0);

    // Clean miss: 1 detect + 5 fetch + 1 update stall cycles.
    access(1'b1, 1'b0, 8'h00, 8'h00, "rd00");
    check("rd00_stall", stalls, 7);
    check("rd00_sawrd", {31'd0, saw_rd}, 32'd1);
    check("rd00_raddr", {26'd0, rd_addr}, 32'h00);
    check("rd00_sawwr", {31'd0, saw_wr}, 32'd0);
    check("rd00_data",  {24'd0, rdata}, 32'hAA);

    // Read hit on the same line.
    access(1'b1, 1'b0, 8'h01, 8'h00, "rd01");
    check("rd01_stall", stalls, 0);
    check("rd01_sawrd", {31'd0, saw_rd}, 32'd0);
    check("rd01_data",  {24'd0, rdata}, 32'hBB);

    // Write hit, then read it back.
    access(1'b0, 1'b1, 8'h02, 8'h55, "wr02");
    check("wr02_stall", stalls, 0);
    check("wr02_mem",   {30'd0, saw_rd, saw_wr}, 32'd0);
    access(1'b1, 1'b0, 8'h02, 8'h00, "rd02");
    check("rd02_stall", stalls, 0);
    check("rd02_mem",   {30'd0, saw_rd, saw_wr}, 32'd0);
    check("rd02_data",  {24'd0, rdata}, 32'h55);

    // Conflict on line 0 with dirty victim: 1 + 5 writeback + 5 fetch + 1.
    access(1'b1, 1'b0, 8'h22, 8'h00, "rd22");
    check("rd22_stall", stalls, 12);
    check("rd22_sawwr", {31'd0, saw_wr}, 32'd1);
    check("rd22_waddr", {26'd0, wr_addr}, 32'h00);
    check("rd22_wdata", wr_data, 32'hDD55BBAA);
    check("rd22_raddr", {26'd0, rd_addr}, 32'h08);
    check("rd22_data",  {24'd0, rdata}, 32'h33);
    check("mem00_wb",   mem[6'h00], 32'hDD55BBAA);

    // Write miss to invalid line 1: fetch only, then merge.
    access(1'b0, 1'b1, 8'h47, 8'h99, "wr47");
    check("wr47_stall", stalls, 7);
    check("wr47_sawwr", {31'd0, saw_wr}, 32'd0);
    check("wr47_raddr", {26'd0, rd_addr}, 32'h11);
    access(1'b1, 1'b0, 8'h47, 8'h00, "rd47");
    check("rd47_stall", stalls, 0);
    check("rd47_data",  {24'd0, rdata}, 32'h99);
    access(1'b1, 1'b0, 8'h44, 8'h00, "rd44");
    check("rd44_data",  {24'd0, rdata}, 32'h21);

    // Conflicting miss on line 1 writes back the merged dirty line.
    access(1'b1, 1'b0, 8'h07, 8'h00, "rd07");
    check("rd07_stall", stalls, 12);
    check("rd07_waddr", {26'd0, wr_addr}, 32'h11);
    check("rd07_wdata", wr_data, 32'h99654321);
    check("rd07_raddr", {26'd0, rd_addr}, 32'h01);
    check("rd07_data",  {24'd0, rdata}, 32'hA1);

    // Reset during FETCH of a clean miss on line 0 (tag 3).
    @(posedge clk);
    #1;
    cpu_read = 1'b1; cpu_address = 8'h60;
    repeat (3) @(negedge clk);
    check("rstf_mrd_pre",  {31'd0, mem_read}, 32'd1);
    check("rstf_busy_pre", {31'd0, busywait}, 32'd1);
    rst = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstf_mrd",  {31'd0, mem_read}, 32'd0);
    check("rstf_mwr",  {31'd0, mem_write}, 32'd0);
    check("rstf_busy", {31'd0, busywait}, 32'd0);

    // Line 0 was invalidated: reading 0x00 misses again.
    access(1'b1, 1'b0, 8'h00, 8'h00, "rd00b");
    check("rd00b_stall", stalls, 7);
    check("rd00b_sawwr", {31'd0, saw_wr}, 32'd0);
    check("rd00b_raddr", {26'd0, rd_addr}, 32'h00);
    check("rd00b_data",  {24'd0, rdata}, 32'hAA);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
